sram_like_arbiter: RTL
======================

// Module: sram_like_arbiter
// PURPOSE
//  Shares one sram-like bus port (to the AXI bridge) between the instruction cache (M0)
//  and the data cache (M1). Exactly one transaction is outstanding at a time.
//  The arbiter sequences each transaction as grant -> address handshake -> data handshake.
//  It sits between i_cache/d_cache and the sram-like-to-AXI converter.
// PARAMETERS
//  FIXED_PRIO  0   0: round-robin when both request; 1: M1 (data) always wins
//  AW          32  address width
//  DW          32  data width
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous reset, active-high
//  m0_req        in   1   inst-side request; held high until m0_addr_ok
//  m0_wr         in   1   write flag
//  m0_size       in   2   access size
//  m0_addr       in   AW  byte address
//  m0_wdata      in   DW  write data
//  m0_rdata      out  DW  read data; valid when m0_data_ok
//  m0_addr_ok    out  1   address accepted
//  m0_data_ok    out  1   transaction done
//  m1_*          same set as m0_*, for the data side
//  s_req, s_wr, s_size, s_addr, s_wdata   out   to bridge
//  s_rdata       in   DW  from bridge
//  s_addr_ok     in   1   from bridge
//  s_data_ok     in   1   from bridge
// BEHAVIOUR
//  States:
//  - IDLE: no transaction in flight.
//  - ADDR: s_req is driven from the granted master.
//  - DATA: waiting for s_data_ok.
//  Registers: state, gnt (0=M0, 1=M1), last (last granted master).
//  IDLE transitions:
//  - If any mN_req: gnt <= winner, state <= ADDR. No outputs are asserted in the arbitration cycle.
//  - Arbitration therefore adds 1 cycle of latency.
//  Winner selection:
//  - Only one master requesting: that master wins.
//  - Both requesting, FIXED_PRIO=1: M1 wins.
//  - Both requesting, FIXED_PRIO=0: the master != last wins.
//  ADDR behaviour:
//  - s_req = req of gnt master.
//  - s_wr/s_size/s_addr/s_wdata are muxed combinationally from the gnt master.
//  - mgnt_addr_ok = s_addr_ok & s_req.
//  - On s_addr_ok: last <= gnt.
//    - If s_data_ok is also high: state <= IDLE, with mgnt_addr_ok and mgnt_data_ok in the same cycle.
//    - Otherwise: state <= DATA.
//  - Granted master drops req without addr_ok (protocol abort): state <= IDLE, no handshake forwarded.
//  DATA behaviour:
//  - s_req = 0.
//  - mgnt_data_ok = s_data_ok; on s_data_ok, state <= IDLE.
//  - New requests from either master are ignored until IDLE; mN_req stays pending.
//  Output rules:
//  - m0_rdata = m1_rdata = s_rdata (broadcast); only mgnt_data_ok qualifies it.
//  - The non-granted master never sees addr_ok or data_ok.
//  - In IDLE and DATA, s_* address/data outputs still mux from gnt; s_req = 0.
//  Reset:
//  - state = IDLE, gnt = 0, last = 1 (M0 wins the first tie).
//  - All *_addr_ok, *_data_ok and s_req are 0.
//  - Reset mid-transaction abandons it; the bridge must be reset together with the arbiter.
// TESTING
//  1. After reset, m0_req with addr=0xBFC00000; bridge gives addr_ok at cycle 2 and data_ok=0x3C080001 at cycle 4
//     -> s_req high only at cycle 1..2; m0_data_ok with m0_rdata=0x3C080001; m1 sees no ok pulses.
//  2. m0_req and m1_req both rise in the same cycle (FIXED_PRIO=0, post-reset)
//     -> M0 served first, then M1 granted in the first IDLE cycle after M0's data_ok.
//  3. Repeat case 2 three times, keeping both requests high
//     -> grant order M0, M1, M0, M1 with no starvation.
//  4. FIXED_PRIO=1 with both requesting continuously
//     -> M1 served every transaction; M0 is served only when m1_req=0.
//  5. Bridge asserts s_addr_ok and s_data_ok in the same cycle
//     -> mgnt_addr_ok and mgnt_data_ok pulse together; state returns to IDLE next cycle.
//  6. rst asserted while in DATA
//     -> next cycle state=IDLE and all ok outputs are 0; a later m1_req (write, 0x1FAF0000) completes normally.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like bridge port between the instruction cache (M0)
// and the data cache (M1). One transaction is in flight at a time, sequenced as
// grant -> address handshake -> data handshake. The handshake returns (addr_ok, data_ok)
// are combinational pass-throughs of the bridge, qualified by the granted master.
`timescale 1ns/1ps
module sram_like_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    // instruction side
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [1:0]    m0_size,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_addr_ok,
    output logic          m0_data_ok,
    // data side
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [1:0]    m1_size,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_addr_ok,
    output logic          m1_data_ok,
    // bridge side
    output logic          s_req,
    output logic          s_wr,
    output logic [1:0]    s_size,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_addr_ok,
    input  logic          s_data_ok
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   gnt_q,   gnt_d;    // 0 = M0, 1 = M1
    logic   last_q,  last_d;   // master that completed the last address handshake

    logic   gnt_req;
    logic   winner;
    logic   addr_ok_c;
    logic   data_ok_c;

    // State, grant and round-robin history registers; last=1 lets M0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Arbitration, transaction sequencing and handshake generation.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        s_req     = 1'b0;
        addr_ok_c = 1'b0;
        data_ok_c = 1'b0;

        gnt_req = gnt_q ? m1_req : m0_req;
        if (m0_req && m1_req) begin
            winner = FIXED_PRIO ? 1'b1 : ~last_q;
        end else begin
            winner = m1_req;
        end

        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d   = winner;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!gnt_req) begin
                    // master withdrew before the bridge accepted: abandon quietly
                    state_d = S_IDLE;
                end else begin
                    s_req = 1'b1;
                    if (s_addr_ok) begin
                        addr_ok_c = 1'b1;
                        last_d    = gnt_q;
                        if (s_data_ok) begin
                            data_ok_c = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (s_data_ok) begin
                    data_ok_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request payload always follows the current grant.
    assign s_wr    = gnt_q ? m1_wr    : m0_wr;
    assign s_size  = gnt_q ? m1_size  : m0_size;
    assign s_addr  = gnt_q ? m1_addr  : m0_addr;
    assign s_wdata = gnt_q ? m1_wdata : m0_wdata;

    // Read data is broadcast; only the granted master's data_ok qualifies it.
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign m0_addr_ok = addr_ok_c & ~gnt_q;
    assign m1_addr_ok = addr_ok_c &  gnt_q;
    assign m0_data_ok = data_ok_c & ~gnt_q;
    assign m1_data_ok = data_ok_c &  gnt_q;

endmodule
